// File: rtl/signed_div_pkg.sv
// Shared types and helpers for the sequential signed divider.
// Contents: state_t (IDLE, ABS, DIV, FIX, DONE), W_DEFAULT, clog2().
package signed_div_pkg;

  localparam int unsigned W_DEFAULT = 32;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ABS  = 3'd1,
    DIV  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;

  // Bits needed to count 0..v-1; at least 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 1;
    while ((64'd1 << r) < 64'(v)) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/signed_div_abs_stage.sv
// Combinational operand preprocessing for the signed divider.
// Ports:
//   a, b      in   W  raw two's-complement dividend/divisor
//   abs_a_c   out  W  |a| as unsigned (|-2^(W-1)| = 2^(W-1))
//   abs_b_c   out  W  |b| as unsigned
//   q_neg_c   out  1  quotient must be negated
//   r_neg_c   out  1  remainder must be negated (follows dividend sign)
//   dbz_c     out  1  divisor is zero
module signed_div_abs_stage
  import signed_div_pkg::*;
#(
  parameter int unsigned W = W_DEFAULT
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] abs_a_c,
  output logic [W-1:0] abs_b_c,
  output logic         q_neg_c,
  output logic         r_neg_c,
  output logic         dbz_c
);

  // Two's-complement negate; the most negative value maps onto itself,
  // which read as unsigned is exactly its magnitude.
  always_comb begin
    abs_a_c = a[W-1] ? (~a + W'(1)) : a;
    abs_b_c = b[W-1] ? (~b + W'(1)) : b;
    q_neg_c = a[W-1] ^ b[W-1];
    r_neg_c = a[W-1];
    dbz_c   = (b == '0);
  end

endmodule

// File: rtl/signed_div_ctrl.sv
// Sequential signed integer divider: magnitude preprocessing, 1-bit/cycle
// restoring division, sign fix-up. Truncating semantics (quotient toward
// zero, remainder takes the dividend sign).
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid / in_ready      operand handshake (in_ready high only in IDLE)
//   a, b                     dividend, divisor (two's complement, W bits)
//   out_valid / out_ready    result handshake, result held until accepted
//   quotient, remainder      signed results
//   div_by_zero              divisor was zero for this result
// Build option: define SIGNED_DIV_ZERO_BYPASS_EN to skip the iteration for a
// zero divisor and return quotient = -1, remainder = a in 3 cycles.
module signed_div_ctrl
  import signed_div_pkg::*;
#(
  parameter int unsigned W = W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         div_by_zero
);

  localparam int unsigned CW = clog2(W);

  state_t        state, state_nxt;
  logic [W-1:0]  a_q, a_nxt;
  logic [W-1:0]  b_q, b_nxt;
  logic [W-1:0]  dvs_q, dvs_nxt;     // |b|
  logic [W-1:0]  shq_q, shq_nxt;     // dividend shifts out, quotient shifts in
  logic [W-1:0]  prem_q, prem_nxt;   // partial remainder, always < |b| (or = |a| prefix when b==0)
  logic          q_neg_q, q_neg_nxt;
  logic          r_neg_q, r_neg_nxt;
  logic          dbz_q, dbz_nxt;
  logic [CW-1:0] cnt_q, cnt_nxt;
  logic          in_ready_nxt;
  logic          out_valid_nxt;
  logic [W-1:0]  quotient_nxt;
  logic [W-1:0]  remainder_nxt;
  logic          div_by_zero_nxt;

  logic [W-1:0]  abs_a_c, abs_b_c;
  logic          q_neg_c, r_neg_c, dbz_c;

  // (W+1)-bit working remainder for one restoring step
  logic [W:0]    p_sh_c;
  logic [W:0]    p_diff_c;
  logic          p_ge_c;

  signed_div_abs_stage #(.W(W)) u_abs (
    .a       (a_q),
    .b       (b_q),
    .abs_a_c (abs_a_c),
    .abs_b_c (abs_b_c),
    .q_neg_c (q_neg_c),
    .r_neg_c (r_neg_c),
    .dbz_c   (dbz_c)
  );

  // Restoring step datapath
  always_comb begin
    p_sh_c   = {prem_q, shq_q[W-1]};
    p_diff_c = p_sh_c - {1'b0, dvs_q};
    p_ge_c   = (p_sh_c >= {1'b0, dvs_q});
  end

  // Next-state and next-register logic
  always_comb begin
    state_nxt       = state;
    a_nxt           = a_q;
    b_nxt           = b_q;
    dvs_nxt         = dvs_q;
    shq_nxt         = shq_q;
    prem_nxt        = prem_q;
    q_neg_nxt       = q_neg_q;
    r_neg_nxt       = r_neg_q;
    dbz_nxt         = dbz_q;
    cnt_nxt         = cnt_q;
    quotient_nxt    = quotient;
    remainder_nxt   = remainder;
    div_by_zero_nxt = div_by_zero;

    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          a_nxt     = a;
          b_nxt     = b;
          state_nxt = ABS;
        end
      end
      ABS: begin
        shq_nxt   = abs_a_c;
        dvs_nxt   = abs_b_c;
        prem_nxt  = '0;
        q_neg_nxt = q_neg_c;
        r_neg_nxt = r_neg_c;
        dbz_nxt   = dbz_c;
        cnt_nxt   = '0;
`ifdef SIGNED_DIV_ZERO_BYPASS_EN
        state_nxt = dbz_c ? FIX : DIV;
`else
        state_nxt = DIV;
`endif
      end
      DIV: begin
        if (p_ge_c) begin
          prem_nxt = p_diff_c[W-1:0];
          shq_nxt  = {shq_q[W-2:0], 1'b1};
        end else begin
          prem_nxt = p_sh_c[W-1:0];
          shq_nxt  = {shq_q[W-2:0], 1'b0};
        end
        cnt_nxt = cnt_q + CW'(1);
        if (cnt_q == CW'(W - 1)) state_nxt = FIX;
      end
      FIX: begin
        quotient_nxt    = q_neg_q ? (~shq_q + W'(1)) : shq_q;
        remainder_nxt   = r_neg_q ? (~prem_q + W'(1)) : prem_q;
        div_by_zero_nxt = dbz_q;
`ifdef SIGNED_DIV_ZERO_BYPASS_EN
        if (dbz_q) begin
          quotient_nxt  = '1;
          remainder_nxt = a_q;
        end
`endif
        state_nxt = DONE;
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    in_ready_nxt  = (state_nxt == IDLE);
    out_valid_nxt = (state_nxt == DONE);
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      dvs_q       <= '0;
      shq_q       <= '0;
      prem_q      <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      dbz_q       <= 1'b0;
      cnt_q       <= '0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state       <= state_nxt;
      a_q         <= a_nxt;
      b_q         <= b_nxt;
      dvs_q       <= dvs_nxt;
      shq_q       <= shq_nxt;
      prem_q      <= prem_nxt;
      q_neg_q     <= q_neg_nxt;
      r_neg_q     <= r_neg_nxt;
      dbz_q       <= dbz_nxt;
      cnt_q       <= cnt_nxt;
      in_ready    <= in_ready_nxt;
      out_valid   <= out_valid_nxt;
      quotient    <= quotient_nxt;
      remainder   <= remainder_nxt;
      div_by_zero <= div_by_zero_nxt;
    end
  end

endmodule

// File: tb/tb_signed_div_ctrl.sv
// Directed bench for signed_div_ctrl (W = 32).
module tb_signed_div_ctrl;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int passed = 0;
  int total  = 0;

  signed_div_ctrl #(.W(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Wait for out_valid, sampling on falling edges; returns falling edges
  // counted from the accept edge (first falling edge after it = 1).
  task automatic wait_result(output int lat);
    int k;
    k = 1;
    while (out_valid !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    lat = k;
  endtask

  // Present operands, collect result, then accept it.
  task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [W-1:0] eq, input logic [W-1:0] er, input logic ed,
                        input int elat);
    int lat;
    @(negedge clk);
    chk({tag, ".in_ready"}, W'(in_ready), W'(1));
    in_valid = 1'b1;
    a = av;
    b = bv;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    wait_result(lat);
    chk({tag, ".out_valid"}, W'(out_valid), W'(1));
    chk({tag, ".latency"}, W'(lat), W'(elat));
    chk({tag, ".quotient"}, quotient, eq);
    chk({tag, ".remainder"}, remainder, er);
    chk({tag, ".dbz"}, W'(div_by_zero), W'(ed));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, ".drop_valid"}, W'(out_valid), W'(0));
  endtask

  initial begin
    int lat;
    logic [W-1:0] hq, hr;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.in_ready", W'(in_ready), W'(1));
    chk("rst.out_valid", W'(out_valid), W'(0));
    chk("rst.quotient", quotient, W'(0));
    chk("rst.remainder", remainder, W'(0));
    chk("rst.dbz", W'(div_by_zero), W'(0));
    rst = 1'b0;

    // out_ready with nothing pending must not disturb IDLE
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("idle_ready.out_valid", W'(out_valid), W'(0));

    run_op("p100_p7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 35);
    run_op("n100_p7", 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 35);
    run_op("p100_n7", 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2, 1'b0, 35);
    run_op("n100_n7", 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14, 32'hFFFFFFFE, 1'b0, 35);
    run_op("ovf", 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b0, 35);
`ifdef SIGNED_DIV_ZERO_BYPASS_EN
    run_op("p5_z", 32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 1'b1, 3);
    run_op("n5_z", 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFB, 1'b1, 3);
`else
    run_op("p5_z", 32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 1'b1, 35);
    run_op("n5_z", 32'hFFFFFFFB, 32'd0, 32'd1, 32'hFFFFFFFB, 1'b1, 35);
`endif

    // Backpressure: hold result 10 cycles, inputs pulsed meanwhile are dropped
    @(negedge clk);
    in_valid = 1'b1;
    a = 32'd100;
    b = 32'd7;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    wait_result(lat);
    chk("hold.latency", W'(lat), W'(35));
    hq = quotient;
    hr = remainder;
    chk("hold.q0", hq, W'(14));
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      a = 32'd77;
      b = 32'd3;
      @(negedge clk);
      chk("hold.valid", W'(out_valid), W'(1));
      chk("hold.in_ready", W'(in_ready), W'(0));
      chk("hold.quotient", quotient, W'(14));
      chk("hold.remainder", remainder, W'(2));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("hold.release_valid", W'(out_valid), W'(0));
    chk("hold.release_ready", W'(in_ready), W'(1));
    run_op("p50_n3", 32'd50, 32'hFFFFFFFD, 32'hFFFFFFF0, 32'd2, 1'b0, 35);

    // Reset during DIV (count = 12)
    @(negedge clk);
    in_valid = 1'b1;
    a = 32'd100;
    b = 32'd7;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (12) @(posedge clk);
    @(negedge clk);
    chk("mid.in_ready_busy", W'(in_ready), W'(0));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid.in_ready", W'(in_ready), W'(1));
    chk("mid.out_valid", W'(out_valid), W'(0));
    chk("mid.quotient", quotient, W'(0));
    run_op("p9_p4", 32'd9, 32'd4, 32'd2, 32'd1, 1'b0, 35);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
